// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with baud tick divider, 3-sample
// majority voting, optional parity, 1/2 stop bits and a show-ahead FIFO whose
// entries carry per-word parity and framing error flags.
//
// Read handshake: the head entry (dout, dout_perr, dout_ferr) is valid whenever
// empty = 0; a pop happens on a rising edge where rd_en = 1 and empty = 0, and
// rd_en while empty is ignored. There is no backpressure toward the line: a
// frame completing while the FIFO is full is dropped and sets sticky overrun.
module uart_rx_fifo #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CLKS_PER_TICK = 1,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_perr,
  output logic                 dout_ferr,
  output logic                 empty,
  output logic                 full,
  output logic                 rx_done_tick,
  output logic                 overrun,
  output logic [2:0]           dbg_state
);

  localparam int DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int N_W   = 4;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_TICK - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [S_W-1:0]   S_MID     = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0]   S_ONE     = S_W'(1);
  localparam logic [N_W-1:0]   N_DLAST   = N_W'(DATA_BITS - 1);
  localparam logic [N_W-1:0]   N_SLAST   = N_W'(STOP_BITS - 1);
  localparam logic [N_W-1:0]   N_ONE     = N_W'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [AW:0]      CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]      CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // synchroniser, divider and sampling history
  logic                 r_sync1, r_sync2;
  logic [DIV_W-1:0]     r_div;
  logic                 w_tick;
  logic [1:0]           r_hist;
  logic                 w_maj;

  // receiver FSM and its datapath
  state_t               r_state, w_state_next;
  logic [S_W-1:0]       r_s, w_s_next;
  logic [N_W-1:0]       r_n, w_n_next;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_next;
  logic                 r_perr, w_perr_next;
  logic                 r_ferr, w_ferr_next;
  logic                 w_push;
  logic                 r_done;

  // FIFO
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic                 r_overrun;
  logic                 w_empty, w_full, w_pop, w_wr, w_drop;
  logic [EW-1:0]        w_wdata, w_head;

  // two-flop synchroniser; both flops reset high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // free-running s_tick divider
  always_ff @(posedge clk) begin
    if (!reset)       r_div <= '0;
    else if (w_tick)  r_div <= '0;
    else              r_div <= r_div + DIV_ONE;
  end

  assign w_tick = (r_div == DIV_LAST);

  // two previous line samples, taken on each s_tick, for majority voting
  always_ff @(posedge clk) begin
    if (!reset)       r_hist <= 2'b11;
    else if (w_tick)  r_hist <= {r_hist[0], r_sync2};
  end

  assign w_maj = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shreg <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_shreg <= w_shreg_next;
      r_perr  <= w_perr_next;
      r_ferr  <= w_ferr_next;
      r_done  <= w_push;
    end
  end

  // FSM next-state and datapath update; everything advances only on s_tick
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_shreg_next = r_shreg;
    w_perr_next  = r_perr;
    w_ferr_next  = r_ferr;
    w_push       = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_sync2) begin
            w_state_next = ST_START;
            w_s_next     = '0;
            w_perr_next  = 1'b0;
            w_ferr_next  = 1'b0;
          end
        end
        ST_START: begin
          if (r_s == S_MID) begin
            if (!w_maj) begin
              w_state_next = ST_DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_s_next = r_s + S_ONE;
          end
        end
        ST_DATA: begin
          if (r_s == S_LAST) begin
            w_shreg_next = {w_maj, r_shreg[DATA_BITS-1:1]};
            w_s_next     = '0;
            if (r_n == N_DLAST) begin
              w_n_next     = '0;
              w_state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              w_n_next = r_n + N_ONE;
            end
          end else begin
            w_s_next = r_s + S_ONE;
          end
        end
        ST_PARITY: begin
          if (r_s == S_LAST) begin
            // even: data ^ parity bit must be 0; odd: must be 1
            w_perr_next  = (PARITY == 2) ? ~(^r_shreg ^ w_maj) : (^r_shreg ^ w_maj);
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = ST_STOP;
          end else begin
            w_s_next = r_s + S_ONE;
          end
        end
        ST_STOP: begin
          if (r_s == S_LAST) begin
            w_ferr_next = r_ferr | ~w_maj;
            w_s_next    = '0;
            if (r_n == N_SLAST) begin
              w_push       = 1'b1;
              w_n_next     = '0;
              w_state_next = ST_IDLE;
            end else begin
              w_n_next = r_n + N_ONE;
            end
          end else begin
            w_s_next = r_s + S_ONE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = rd_en & ~w_empty;
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_wdata = {w_ferr_next, r_perr, r_shreg};

  // FIFO storage; no reset needed because the outputs are gated by empty
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_wdata;
  end

  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign dout         = w_empty ? '0 : w_head[DATA_BITS-1:0];
  assign dout_perr    = w_empty ? 1'b0 : w_head[DATA_BITS];
  assign dout_ferr    = w_empty ? 1'b0 : w_head[DATA_BITS+1];
  assign empty        = w_empty;
  assign full         = w_full;
  assign rx_done_tick = r_done;
  assign overrun      = r_overrun;
  assign dbg_state    = r_state;

endmodule
